alu_sequencer: RTL and testbench

Multi-cycle controller that runs one 8-bit Z80 ALU operation on the nibble-serial ALU block (alu).
- Loads OP1 and OP2 over the ALU data bus.
- Runs the low-nibble pass, then the high-nibble pass, then reads the result back.
- Assembles the Z80 flag byte.
- Sits between the instruction-execution sequencer (valid/ready request side) and alu's control wires and db bus.

---
 rtl/alu_seq_pkg.sv | 83 ++++++++
 rtl/alu_seq_decode.sv | 78 +++++++
 rtl/alu_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcode, state, flag and decode definitions for alu_sequencer
//
// Contents:
//   alu_op_e     request opcode encoding (0 ADD .. 14 SRL, 15 reserved)
//   ST_*         sequencer state codes
//   FLAG_*       bit positions inside the Z80 flag byte
//   RSV_*        {R,S,V} core function selects
//   CF_*, SHIN_* carry-in and shift-in source selects
//   alu_ctl_t    per-opcode control vector produced by alu_seq_decode
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADC  = 4'd1,
    OP_SUB  = 4'd2,
    OP_SBC  = 4'd3,
    OP_AND  = 4'd4,
    OP_XOR  = 4'd5,
    OP_OR   = 4'd6,
    OP_CP   = 4'd7,
    OP_RLC  = 4'd8,
    OP_RRC  = 4'd9,
    OP_RL   = 4'd10,
    OP_RR   = 4'd11,
    OP_SLA  = 4'd12,
    OP_SRA  = 4'd13,
    OP_SRL  = 4'd14,
    OP_RSVD = 4'd15
  } alu_op_e;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LD1  = 3'd1;
  localparam logic [2:0] ST_LD2  = 3'd2;
  localparam logic [2:0] ST_LO   = 3'd3;
  localparam logic [2:0] ST_HI   = 3'd4;
  localparam logic [2:0] ST_RD   = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;

  localparam int FLAG_S  = 7;
  localparam int FLAG_Z  = 6;
  localparam int FLAG_Y  = 5;
  localparam int FLAG_H  = 4;
  localparam int FLAG_X  = 3;
  localparam int FLAG_PV = 2;
  localparam int FLAG_N  = 1;
  localparam int FLAG_C  = 0;

  localparam logic [2:0] RSV_ADD = 3'b000;
  localparam logic [2:0] RSV_AND = 3'b001;
  localparam logic [2:0] RSV_XOR = 3'b010;
  localparam logic [2:0] RSV_OR  = 3'b011;

  localparam logic [1:0] CF_ZERO   = 2'd0;
  localparam logic [1:0] CF_ONE    = 2'd1;
  localparam logic [1:0] CF_CARRY  = 2'd2;
  localparam logic [1:0] CF_NCARRY = 2'd3;

  localparam logic [1:0] SHIN_ZERO = 2'd0;
  localparam logic [1:0] SHIN_A7   = 2'd1;
  localparam logic [1:0] SHIN_A0   = 2'd2;
  localparam logic [1:0] SHIN_CF   = 2'd3;

  typedef struct packed {
    logic [2:0] rsv;
    logic       op2_pos;
    logic       sub;
    logic       logic_op;
    logic       and_op;
    logic       shift;
    logic [1:0] shin_sel;
    logic       right;
    logic       sra;
    logic [1:0] cf_sel;
    logic       cp;
    logic       err;
  } alu_ctl_t;

  // Subtract family: operand B enters the core inverted and N is set.
  function automatic logic is_sub_op(input alu_op_e op);
    return (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// rtl/alu_seq_decode.sv - combinational opcode to control-vector decode for alu_sequencer
//
// Ports:
//   op   in   4  request opcode
//   ctl  out     alu_ctl_t control vector (RSV, op2 polarity, families, shift setup, carry-in, err)
// Build option ALU_SEQ_SHIFT_EN: when undefined, opcodes 8-14 decode as errors and
// never request the input shifter.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  alu_op_e  op,
  output alu_ctl_t ctl
);

  always_comb begin
    ctl          = '0;
    ctl.rsv      = RSV_ADD;
    ctl.sub      = is_sub_op(op);
    ctl.op2_pos  = !is_sub_op(op);
    ctl.cf_sel   = CF_ZERO;
    ctl.shin_sel = SHIN_ZERO;
    case (op)
      OP_ADD: ctl.cf_sel = CF_ZERO;
      OP_ADC: ctl.cf_sel = CF_CARRY;
      OP_SUB: ctl.cf_sel = CF_ONE;
      OP_SBC: ctl.cf_sel = CF_NCARRY;
      OP_CP: begin
        ctl.cf_sel = CF_ONE;
        ctl.cp     = 1'b1;
      end
      OP_AND: begin
        ctl.rsv      = RSV_AND;
        ctl.logic_op = 1'b1;
        ctl.and_op   = 1'b1;
      end
      OP_XOR: begin
        ctl.rsv      = RSV_XOR;
        ctl.logic_op = 1'b1;
      end
      OP_OR: begin
        ctl.rsv      = RSV_OR;
        ctl.logic_op = 1'b1;
      end
`ifdef ALU_SEQ_SHIFT_EN
      OP_RLC: begin
        ctl.shift    = 1'b1;
        ctl.shin_sel = SHIN_A7;
      end
      OP_RRC: begin
        ctl.shift    = 1'b1;
        ctl.shin_sel = SHIN_A0;
        ctl.right    = 1'b1;
      end
      OP_RL: begin
        ctl.shift    = 1'b1;
        ctl.shin_sel = SHIN_CF;
      end
      OP_RR: begin
        ctl.shift    = 1'b1;
        ctl.shin_sel = SHIN_CF;
        ctl.right    = 1'b1;
      end
      OP_SLA: ctl.shift = 1'b1;
      OP_SRA: begin
        ctl.shift = 1'b1;
        ctl.right = 1'b1;
        ctl.sra   = 1'b1;
      end
      OP_SRL: begin
        ctl.shift = 1'b1;
        ctl.right = 1'b1;
      end
`endif
      default: ctl.err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle controller running one 8-bit Z80 op on the nibble-serial alu
//
// Ports:
//   clk, nreset                      clock, synchronous active-low reset
//   req_valid/req_ready              request handshake; req_op/req_a/req_b/req_cf payload
//   resp_valid                       one-cycle completion pulse; resp_result/resp_flags/resp_err
//   db_out/db_drive/db_in            split alu data bus
//   alu_*  (outputs)                 alu bus enables, shifter, operand mux and core controls
//   alu_core_cf_out, alu_shift_out,
//   alu_parity_out, alu_zero         alu feedback
// Build option ALU_SEQ_SHIFT_EN enables opcodes 8-14 (see alu_seq_decode).
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic       req_cf,
  output logic       resp_valid,
  output logic [7:0] resp_result,
  output logic [7:0] resp_flags,
  output logic       resp_err,
  output logic [7:0] db_out,
  output logic       db_drive,
  input  logic [7:0] db_in,
  output logic       alu_oe,
  output logic       alu_op1_oe,
  output logic       alu_op2_oe,
  output logic       alu_res_oe,
  output logic       alu_shift_oe,
  output logic       alu_bs_oe,
  output logic       alu_shift_enable,
  output logic       alu_shift_in,
  output logic       alu_shift_right,
  output logic       alu_shift_sra,
  output logic       alu_op1_sel_bus,
  output logic       alu_op1_sel_low,
  output logic       alu_op1_sel_zero,
  output logic       alu_op2_sel_bus,
  output logic       alu_op2_sel_lq,
  output logic       alu_op2_sel_zero,
  output logic       alu_sel_op2_pos,
  output logic       alu_sel_op2_low,
  output logic       alu_op_low,
  output logic       alu_core_cf_in,
  output logic       alu_core_R,
  output logic       alu_core_S,
  output logic       alu_core_V,
  output logic       alu_parity_in,
  input  logic       alu_core_cf_out,
  input  logic       alu_shift_out,
  input  logic       alu_parity_out,
  input  logic       alu_zero
);

  logic [2:0] state;
  logic [3:0] op_q;
  logic [7:0] a_q, b_q;
  logic       cf_q;
  logic       sc, hc, zl, pl, cc, zh, p;
  alu_ctl_t   ctl;
  alu_op_e    dec_op;
  logic [7:0] done_result, done_flags;
  logic       arith, b7x;

  // In IDLE the live request is decoded so the error path can be taken at accept.
  assign dec_op = alu_op_e'((state == ST_IDLE) ? req_op : op_q);

  alu_seq_decode u_decode (
    .op  (dec_op),
    .ctl (ctl)
  );

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_DONE);

  // Result and flags are formed from db_in while the result is on the bus in RD.
  always_comb begin
    arith       = !ctl.logic_op && !ctl.shift;
    b7x         = ctl.sub ? ~b_q[7] : b_q[7];
    done_result = ctl.cp ? a_q : db_in;
    done_flags  = '0;
    done_flags[FLAG_S] = db_in[7];
    done_flags[FLAG_Z] = zl & zh;
    done_flags[FLAG_Y] = ctl.cp ? b_q[5] : db_in[5];
    done_flags[FLAG_X] = ctl.cp ? b_q[3] : db_in[3];
    done_flags[FLAG_N] = ctl.sub;
    if (ctl.and_op)
      done_flags[FLAG_H] = 1'b1;
    else if (arith)
      done_flags[FLAG_H] = hc ^ ctl.sub;
    if (ctl.shift)
      done_flags[FLAG_C] = sc;
    else if (arith)
      done_flags[FLAG_C] = cc ^ ctl.sub;
    done_flags[FLAG_PV] = arith ? ((a_q[7] == b7x) && (db_in[7] != a_q[7])) : p;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state       <= ST_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cf_q        <= 1'b0;
      sc          <= 1'b0;
      hc          <= 1'b0;
      zl          <= 1'b0;
      pl          <= 1'b0;
      cc          <= 1'b0;
      zh          <= 1'b0;
      p           <= 1'b0;
      resp_result <= '0;
      resp_flags  <= '0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q <= req_op;
            a_q  <= req_a;
            b_q  <= req_b;
            cf_q <= req_cf;
            if (ctl.err) begin
              state       <= ST_DONE;
              resp_result <= req_a;
              resp_flags  <= '0;
              resp_err    <= 1'b1;
            end else begin
              state <= ST_LD1;
            end
          end
        end
        ST_LD1: begin
          sc    <= alu_shift_out;
          state <= ST_LD2;
        end
        ST_LD2: state <= ST_LO;
        ST_LO: begin
          hc    <= alu_core_cf_out;
          zl    <= alu_zero;
          pl    <= alu_parity_out;
          state <= ST_HI;
        end
        ST_HI: begin
          cc    <= alu_core_cf_out;
          zh    <= alu_zero;
          p     <= alu_parity_out;
          state <= ST_RD;
        end
        ST_RD: begin
          resp_result <= done_result;
          resp_flags  <= done_flags;
          resp_err    <= 1'b0;
          state       <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign alu_op1_oe       = 1'b0;
  assign alu_op2_oe       = 1'b0;
  assign alu_bs_oe        = 1'b0;
  assign alu_op1_sel_low  = 1'b0;
  assign alu_op1_sel_zero = 1'b0;
  assign alu_op2_sel_lq   = 1'b0;

  // Moore decode of the alu control wires; everything idles at 0.
  always_comb begin
    db_out           = '0;
    db_drive         = 1'b0;
    alu_oe           = 1'b0;
    alu_res_oe       = 1'b0;
    alu_shift_oe     = 1'b0;
    alu_shift_enable = 1'b0;
    alu_shift_in     = 1'b0;
    alu_shift_right  = 1'b0;
    alu_shift_sra    = 1'b0;
    alu_op1_sel_bus  = 1'b0;
    alu_op2_sel_bus  = 1'b0;
    alu_op2_sel_zero = 1'b0;
    alu_sel_op2_pos  = 1'b0;
    alu_sel_op2_low  = 1'b0;
    alu_op_low       = 1'b0;
    alu_core_cf_in   = 1'b0;
    alu_core_R       = 1'b0;
    alu_core_S       = 1'b0;
    alu_core_V       = 1'b0;
    alu_parity_in    = 1'b0;
    case (state)
      ST_LD1: begin
        db_drive        = 1'b1;
        db_out          = a_q;
        alu_op1_sel_bus = 1'b1;
        alu_shift_oe    = 1'b1;
        if (ctl.shift) begin
          alu_shift_enable = 1'b1;
          alu_shift_right  = ctl.right;
          alu_shift_sra    = ctl.sra;
          case (ctl.shin_sel)
            SHIN_A7: alu_shift_in = a_q[7];
            SHIN_A0: alu_shift_in = a_q[0];
            SHIN_CF: alu_shift_in = cf_q;
            default: alu_shift_in = 1'b0;
          endcase
        end
      end
      ST_LD2: begin
        // Shifts run as "shifted A + 0", so op2 is cleared instead of loaded.
        if (ctl.shift) begin
          alu_op2_sel_zero = 1'b1;
        end else begin
          db_drive        = 1'b1;
          db_out          = b_q;
          alu_op2_sel_bus = 1'b1;
        end
      end
      ST_LO: begin
        alu_op_low      = 1'b1;
        alu_sel_op2_low = 1'b1;
        {alu_core_R, alu_core_S, alu_core_V} = ctl.rsv;
        alu_sel_op2_pos = ctl.op2_pos;
        case (ctl.cf_sel)
          CF_ONE:    alu_core_cf_in = 1'b1;
          CF_CARRY:  alu_core_cf_in = cf_q;
          CF_NCARRY: alu_core_cf_in = ~cf_q;
          default:   alu_core_cf_in = 1'b0;
        endcase
      end
      ST_HI: begin
        {alu_core_R, alu_core_S, alu_core_V} = ctl.rsv;
        alu_sel_op2_pos = ctl.op2_pos;
        alu_core_cf_in  = hc;
        alu_parity_in   = pl;
      end
      ST_RD: begin
        alu_res_oe = 1'b1;
        alu_oe     = 1'b1;
      end
      default: db_out = '0;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with a behavioural nibble alu
module tb_alu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nreset, req_valid, req_ready, req_cf;
  logic [3:0] req_op;
  logic [7:0] req_a, req_b;
  logic       resp_valid, resp_err;
  logic [7:0] resp_result, resp_flags;
  logic [7:0] db_out, db_in;
  logic       db_drive;
  logic alu_oe, alu_op1_oe, alu_op2_oe, alu_res_oe, alu_shift_oe, alu_bs_oe;
  logic alu_shift_enable, alu_shift_in, alu_shift_right, alu_shift_sra;
  logic alu_op1_sel_bus, alu_op1_sel_low, alu_op1_sel_zero;
  logic alu_op2_sel_bus, alu_op2_sel_lq, alu_op2_sel_zero;
  logic alu_sel_op2_pos, alu_sel_op2_low, alu_op_low, alu_core_cf_in;
  logic alu_core_R, alu_core_S, alu_core_V, alu_parity_in;
  logic alu_core_cf_out, alu_shift_out, alu_parity_out, alu_zero;

  alu_sequencer dut (
    .clk(clk), .nreset(nreset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cf(req_cf),
    .resp_valid(resp_valid), .resp_result(resp_result), .resp_flags(resp_flags), .resp_err(resp_err),
    .db_out(db_out), .db_drive(db_drive), .db_in(db_in),
    .alu_oe(alu_oe), .alu_op1_oe(alu_op1_oe), .alu_op2_oe(alu_op2_oe), .alu_res_oe(alu_res_oe),
    .alu_shift_oe(alu_shift_oe), .alu_bs_oe(alu_bs_oe),
    .alu_shift_enable(alu_shift_enable), .alu_shift_in(alu_shift_in),
    .alu_shift_right(alu_shift_right), .alu_shift_sra(alu_shift_sra),
    .alu_op1_sel_bus(alu_op1_sel_bus), .alu_op1_sel_low(alu_op1_sel_low), .alu_op1_sel_zero(alu_op1_sel_zero),
    .alu_op2_sel_bus(alu_op2_sel_bus), .alu_op2_sel_lq(alu_op2_sel_lq), .alu_op2_sel_zero(alu_op2_sel_zero),
    .alu_sel_op2_pos(alu_sel_op2_pos), .alu_sel_op2_low(alu_sel_op2_low), .alu_op_low(alu_op_low),
    .alu_core_cf_in(alu_core_cf_in), .alu_core_R(alu_core_R), .alu_core_S(alu_core_S),
    .alu_core_V(alu_core_V), .alu_parity_in(alu_parity_in),
    .alu_core_cf_out(alu_core_cf_out), .alu_shift_out(alu_shift_out),
    .alu_parity_out(alu_parity_out), .alu_zero(alu_zero)
  );

  logic [24:0] ctl_bus;
  assign ctl_bus = {db_drive, alu_oe, alu_op1_oe, alu_op2_oe, alu_res_oe, alu_shift_oe, alu_bs_oe,
                    alu_shift_enable, alu_shift_in, alu_shift_right, alu_shift_sra,
                    alu_op1_sel_bus, alu_op1_sel_low, alu_op1_sel_zero,
                    alu_op2_sel_bus, alu_op2_sel_lq, alu_op2_sel_zero,
                    alu_sel_op2_pos, alu_sel_op2_low, alu_op_low, alu_core_cf_in,
                    alu_core_R, alu_core_S, alu_core_V, alu_parity_in};

  // Behavioural nibble-serial alu: input shifter, operand latches, 4-bit core, result latch.
  logic [7:0] op1 = 8'h00, op2 = 8'h00, res = 8'h00, bus, sh_val;
  logic       sh_in;
  logic [3:0] a_n, b_n, nib;
  logic [4:0] sum;

  always_comb begin
    bus           = db_drive ? db_out : 8'hFF;
    sh_in         = alu_shift_sra ? bus[7] : alu_shift_in;
    sh_val        = bus;
    alu_shift_out = 1'b0;
    if (alu_shift_enable) begin
      if (alu_shift_right) begin
        sh_val        = {sh_in, bus[7:1]};
        alu_shift_out = bus[0];
      end else begin
        sh_val        = {bus[6:0], sh_in};
        alu_shift_out = bus[7];
      end
    end
    a_n = alu_op_low ? op1[3:0] : op1[7:4];
    b_n = alu_sel_op2_low ? op2[3:0] : op2[7:4];
    if (!alu_sel_op2_pos) b_n = ~b_n;
    sum = {1'b0, a_n} + {1'b0, b_n} + {4'b0, alu_core_cf_in};
    case ({alu_core_R, alu_core_S, alu_core_V})
      3'b001:  nib = a_n & b_n;
      3'b010:  nib = a_n ^ b_n;
      3'b011:  nib = a_n | b_n;
      default: nib = sum[3:0];
    endcase
    alu_core_cf_out = ({alu_core_R, alu_core_S, alu_core_V} == 3'b000) ? sum[4] : 1'b0;
    alu_zero        = (nib == 4'h0);
    alu_parity_out  = alu_op_low ? ~^nib : (alu_parity_in ^ (^nib));
    db_in           = (alu_oe && alu_res_oe) ? res : bus;
  end

  always @(posedge clk) begin
    if (alu_op1_sel_bus) op1 <= sh_val;
    if (alu_op2_sel_bus) op2 <= bus;
    else if (alu_op2_sel_zero) op2 <= 8'h00;
    if (alu_op_low) res[3:0] <= nib;
    else if (!alu_oe) res[7:4] <= nib;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  typedef struct packed {
    logic [7:0]  result;
    logic [7:0]  flags;
    logic        err;
    logic [31:0] due;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (resp_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_resp_valid: got 1 expected 0 at cycle %0d", cyc);
      end else begin
        mon_e = sbq.pop_front();
        check("resp_result", resp_result, mon_e.result);
        check("resp_flags", resp_flags, mon_e.flags);
        check("resp_err", resp_err, mon_e.err);
        check("latency_cycle", cyc, mon_e.due);
      end
    end
  end

  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b;
    logic       cf;
    logic [7:0] result, flags;
    logic       err;
    int         lat;
  } vec_t;
  vec_t vecs[13];

  task automatic send(input vec_t v);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
    end
    req_op = v.op; req_a = v.a; req_b = v.b; req_cf = v.cf; req_valid = 1'b1;
    @(posedge clk);
    #1;
    sbq.push_back('{v.result, v.flags, v.err, 32'(cyc + v.lat - 1)});
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got %0d pending expected 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    //            op     a      b      cf    result flags  err lat
    vecs[0]  = '{4'd0, 8'h3A, 8'hC6, 1'b0, 8'h00, 8'h51, 1'b0, 6};
    vecs[1]  = '{4'd2, 8'h80, 8'h01, 1'b0, 8'h7F, 8'h3E, 1'b0, 6};
    vecs[2]  = '{4'd4, 8'hF0, 8'h3C, 1'b0, 8'h30, 8'h34, 1'b0, 6};
    vecs[3]  = '{4'd7, 8'h10, 8'h20, 1'b0, 8'h10, 8'hA3, 1'b0, 6};
    vecs[4]  = '{4'd1, 8'h0F, 8'h00, 1'b1, 8'h10, 8'h10, 1'b0, 6};
    vecs[5]  = '{4'd5, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h44, 1'b0, 6};
    vecs[6]  = '{4'd6, 8'h01, 8'h02, 1'b0, 8'h03, 8'h04, 1'b0, 6};
    vecs[7]  = '{4'd3, 8'h00, 8'h00, 1'b1, 8'hFF, 8'hBB, 1'b0, 6};
    vecs[8]  = '{4'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 8'h94, 1'b0, 6};
    vecs[9]  = '{4'd15, 8'h55, 8'hAA, 1'b1, 8'h55, 8'h00, 1'b1, 1};
`ifdef ALU_SEQ_SHIFT_EN
    vecs[10] = '{4'd10, 8'h81, 8'h00, 1'b0, 8'h02, 8'h01, 1'b0, 6};
    vecs[11] = '{4'd13, 8'h81, 8'h00, 1'b0, 8'hC0, 8'h85, 1'b0, 6};
    vecs[12] = '{4'd9, 8'h01, 8'h00, 1'b0, 8'h80, 8'h81, 1'b0, 6};
`else
    vecs[10] = '{4'd10, 8'h81, 8'h00, 1'b0, 8'h81, 8'h00, 1'b1, 1};
    vecs[11] = '{4'd13, 8'h81, 8'h00, 1'b0, 8'h81, 8'h00, 1'b1, 1};
    vecs[12] = '{4'd9, 8'h01, 8'h00, 1'b0, 8'h01, 8'h00, 1'b1, 1};
`endif

    nreset = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_a = 8'h00; req_b = 8'h00; req_cf = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_result", resp_result, 0);
    check("rst_resp_flags", resp_flags, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_ctl_bus", ctl_bus, 0);
    nreset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      send(vecs[i]);
      wait_drain();
    end

    // Back-to-back issue: second request waits for req_ready.
    send(vecs[1]);
    send(vecs[2]);
    wait_drain();

    // Requests while busy are ignored.
    send(vecs[0]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_op = 4'd15; req_a = 8'hEE; req_valid = 1'b1;
      check("busy_req_ready", req_ready, 0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    wait_drain();

    // Reset during the high-nibble pass drops the op.
    @(negedge clk);
    req_op = 4'd0; req_a = 8'h12; req_b = 8'h34; req_cf = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("lo_op_low", alu_op_low, 1);
    @(negedge clk);
    check("hi_op_low", alu_op_low, 0);
    check("hi_sel_op2_pos", alu_sel_op2_pos, 1);
    nreset = 1'b0;
    @(negedge clk);
    check("midrst_req_ready", req_ready, 1);
    check("midrst_ctl_bus", ctl_bus, 0);
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_resp_result", resp_result, 0);
    check("midrst_resp_flags", resp_flags, 0);
    nreset = 1'b1;
    repeat (10) @(negedge clk);

    // Normal operation resumes after the aborted op.
    send(vecs[3]);
    wait_drain();
    check("queue_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
